// File: rtl/edge_point_extractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : edge_point_extractor_pkg
//  Purpose  : Image geometry and extractor state encoding shared with the
//             edge-detection writer.
//  Revision : 1.0  initial release
// ============================================================================
package edge_point_extractor_pkg;

    localparam int c_image_width = 320;
    localparam int c_start_addr  = 2240;    // line 7, x 0
    localparam int c_end_addr    = 74560;   // line 233, x 0

    localparam int c_addr_w  = 18;
    localparam int c_x_w     = 9;
    localparam int c_y_w     = 8;
    localparam int c_count_w = 17;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_TEST = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } epe_state_t;

    // Elaboration-time only: line number of a linear edge-map address.
    function automatic int line_of(input int addr, input int width);
        return addr / width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_point_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : edge_point_extractor
//  Purpose  : Scans an edge map in memory and emits (x, y) of every nonzero
//             word through a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module edge_point_extractor
    import edge_point_extractor_pkg::*;
#(
    parameter int IMAGE_WIDTH = c_image_width,
    parameter int START_ADDR  = c_start_addr,
    parameter int END_ADDR    = c_end_addr
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pause,
    input  logic                 enable_extraction,
    input  logic [31:0]          data_read,
    output logic [c_addr_w-1:0]  address,
    output logic                 wren,
    output logic                 point_valid,
    input  logic                 point_ready,
    output logic [c_x_w-1:0]     point_x,
    output logic [c_y_w-1:0]     point_y,
    output logic [c_count_w-1:0] edge_count,
    output logic                 extraction_done
);

    localparam logic [c_addr_w-1:0] c_start   = c_addr_w'(START_ADDR);
    localparam logic [c_addr_w-1:0] c_end     = c_addr_w'(END_ADDR);
    localparam logic [c_x_w-1:0]    c_x_last  = c_x_w'(IMAGE_WIDTH - 1);
    localparam logic [c_y_w-1:0]    c_y_first = c_y_w'(line_of(START_ADDR, IMAGE_WIDTH));

    epe_state_t r_state, w_state_nx;

    logic [c_addr_w-1:0]  r_address,     w_address_nx;
    logic [c_x_w-1:0]     r_x,           w_x_nx;
    logic [c_y_w-1:0]     r_y,           w_y_nx;
    logic [c_x_w-1:0]     r_point_x,     w_point_x_nx;
    logic [c_y_w-1:0]     r_point_y,     w_point_y_nx;
    logic                 r_point_valid, w_point_valid_nx;
    logic [c_count_w-1:0] r_edge_count,  w_edge_count_nx;
    logic                 r_done,        w_done_nx;
    logic                 w_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_address     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_point_x     <= '0;
            r_point_y     <= '0;
            r_point_valid <= 1'b0;
            r_edge_count  <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_address     <= w_address_nx;
            r_x           <= w_x_nx;
            r_y           <= w_y_nx;
            r_point_x     <= w_point_x_nx;
            r_point_y     <= w_point_y_nx;
            r_point_valid <= w_point_valid_nx;
            r_edge_count  <= w_edge_count_nx;
            r_done        <= w_done_nx;
        end
    end

    // Everything holds by default, so pause simply skips the update logic.
    always_comb begin
        w_state_nx       = r_state;
        w_address_nx     = r_address;
        w_x_nx           = r_x;
        w_y_nx           = r_y;
        w_point_x_nx     = r_point_x;
        w_point_y_nx     = r_point_y;
        w_point_valid_nx = r_point_valid;
        w_edge_count_nx  = r_edge_count;
        w_done_nx        = r_done;
        w_advance        = 1'b0;

        if (!pause) begin
            if (r_state != ST_IDLE && !enable_extraction) begin
                w_state_nx       = ST_IDLE;
                w_point_valid_nx = 1'b0;
                w_done_nx        = 1'b0;
                w_address_nx     = '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (enable_extraction && !r_done) begin
                            w_address_nx    = c_start;
                            w_x_nx          = '0;
                            w_y_nx          = c_y_first;
                            w_edge_count_nx = '0;
                            w_state_nx      = ST_WAIT;
                        end
                    end
                    ST_WAIT: w_state_nx = ST_TEST;
                    ST_TEST: begin
                        if (data_read != '0) begin
                            w_point_x_nx     = r_x;
                            w_point_y_nx     = r_y;
                            w_point_valid_nx = 1'b1;
                            w_state_nx       = ST_EMIT;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                    ST_EMIT: begin
                        if (point_ready) begin
                            w_point_valid_nx = 1'b0;
                            w_edge_count_nx  = r_edge_count + 1'b1;
                            w_advance        = 1'b1;
                        end
                    end
                    ST_DONE: w_done_nx = 1'b1;
                    default: w_state_nx = ST_IDLE;
                endcase

                // Coordinates follow the address by counting, never by division.
                if (w_advance) begin
                    if (r_address == c_end) begin
                        w_state_nx = ST_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_address_nx = r_address + 1'b1;
                        w_state_nx   = ST_WAIT;
                        if (r_x == c_x_last) begin
                            w_x_nx = '0;
                            w_y_nx = r_y + 1'b1;
                        end else begin
                            w_x_nx = r_x + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign address         = r_address;
    assign wren            = 1'b0;
    assign point_valid     = r_point_valid;
    assign point_x         = r_point_x;
    assign point_y         = r_point_y;
    assign edge_count      = r_edge_count;
    assign extraction_done = r_done;

endmodule
`default_nettype wire

// File: doc/edge_point_extractor.md
EDGE_POINT_EXTRACTOR -- requirements
Module: edge_point_extractor

Interface
REQ-001 Parameters SHALL be: IMAGE_WIDTH, default 320, pixels per line; START_ADDR, default 2240, first edge-map word (line 7, x 0); END_ADDR, default 74560, last edge-map word (line 233, x 0).
REQ-002 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: pause  in  1  freeze: when 1, all state and outputs hold.
REQ-005 Port: enable_extraction  in  1  level start; 0 aborts and clears done.
REQ-006 Port: data_read  in  32  edge-map word from memory; nonzero = edge pixel.
REQ-007 Port: address  out  18  memory read address.
REQ-008 Port: wren  out  1  constant 0; block never writes.
REQ-009 Port: point_valid  out  1  edge coordinate available.
REQ-010 Port: point_ready  in  1  consumer accepts coordinate.
REQ-011 Port: point_x  out  9  edge column, 0..319.
REQ-012 Port: point_y  out  8  edge line, 7..233.
REQ-013 Port: edge_count  out  17  edge points transferred this scan.
REQ-014 Port: extraction_done  out  1  scan complete, held until enable_extraction falls.

Function
REQ-015 Memory latency SHALL be one cycle: address driven after edge k is valid on data_read at edge k+1.
REQ-016 FSM states SHALL be IDLE, WAIT, TEST, EMIT, DONE.
REQ-017 IDLE: on enable_extraction=1 and extraction_done=0 -> address=START_ADDR, x=0, y=START_ADDR/IMAGE_WIDTH, edge_count=0, go WAIT.
REQ-018 WAIT: one cycle for read latency, then TEST.
REQ-019 TEST: data_read!=0 -> latch point_x/point_y, point_valid=1, go EMIT; else ADVANCE.
REQ-020 EMIT: hold point_valid, point_x, point_y stable until edge with point_ready=1 and pause=0; then point_valid=0, edge_count+1, ADVANCE.
REQ-021 ADVANCE: address==END_ADDR -> DONE; else address+1, x+1 with x=IMAGE_WIDTH-1 wrapping to 0 and y+1, go WAIT.
REQ-022 x/y SHALL be tracked by counters; no divider.
REQ-023 DONE: extraction_done=1; stays until enable_extraction=0, then extraction_done=0, go IDLE.
REQ-024 enable_extraction=0 in any non-IDLE state SHALL abort: next cycle IDLE, point_valid=0, extraction_done=0, address=0; edge_count held.
REQ-025 pause=1 SHALL take priority over enable and handshake; no transfer counted while paused.
REQ-026 Throughput: 2 cycles per non-edge pixel, 2 cycles plus ready wait per edge pixel.
REQ-027 edge_count width SHALL cover 72321 pixels without saturation.

Reset
REQ-028 reset=1 SHALL override pause: state IDLE, address=0, wren=0, point_valid=0, point_x=0, point_y=0, edge_count=0, extraction_done=0.
REQ-029 reset mid-scan SHALL discard any pending point; a new scan needs enable_extraction high after reset release.

Structure
REQ-030 IMAGE_WIDTH, START_ADDR, END_ADDR and the FSM state encoding SHALL live in a shared image-geometry package used by the edge-detection writer too.
REQ-031 No sub-module; single FSM with coordinate counter.

Verification
REQ-032 All-zero map, point_ready=1 -> no point_valid, done after 2*72321+1 cycles, edge_count=0, address ends 74560.
REQ-033 Nonzero at 2240, 2559, 2560, 74560 -> points (0,7), (319,7), (0,8), (0,233); edge_count=4.
REQ-034 Edge at 3000, point_ready low 10 cycles -> point_valid, (120,9) held stable 10 cycles, one transfer, edge_count=1.
REQ-035 pause=1 for 5 cycles during EMIT with point_ready=1 -> no transfer until pause=0; address, state frozen.
REQ-036 enable_extraction dropped at address 40000 -> IDLE next cycle, point_valid=0, done=0; re-enable restarts at 2240, edge_count=0.
REQ-037 reset asserted during EMIT with pause=1 -> all outputs at reset values next edge.
